// File: rtl/dmem_lsu.sv
// ----------------------------------------------------------------------------
// dmem_lsu
//   Byte-addressed, little-endian data memory with an integrated RV32
//   load/store unit for the MEM stage. funct3 selects byte/half/word.
//   Byte lanes come from the access size and the low address bits. Loads are
//   sign- or zero-extended. Misaligned, out-of-range and illegal-funct3
//   accesses are rejected and do not modify memory. A response arrives
//   LATENCY cycles after a request is accepted.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (control and response regs)
//   req_valid   request present
//   req_ready   block idle and able to accept
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr    byte address
//   req_wdata   store data (low bytes used for SB/SH)
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load data; 0 for stores and rejected accesses
//   resp_err    access rejected
// ----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int              AW        = $clog2(DEPTH_BYTES);
  localparam logic [XLEN-1:0] DEPTH_L   = XLEN'(DEPTH_BYTES);
  // WAIT lasts LATENCY-1 cycles: the counter runs LATENCY-2 down to 0.
  localparam logic [1:0]      WAIT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       load_resp;

  logic [7:0] mem [DEPTH_BYTES];

  logic [AW-1:0]   idx;
  logic [AW-3:0]   word_sel;
  logic [1:0]      size;
  logic            accept;
  logic            f3_bad;
  logic            misaligned;
  logic            out_of_range;
  logic            acc_err;
  logic [3:0]      lanes;
  logic [XLEN-1:0] wdata_lanes;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] ld_result;

  logic [XLEN-1:0] hold_data_p0;
  logic            hold_err_p0;

  // Right-align the addressed bytes and extend according to funct3.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                  input logic [XLEN-1:0] word,
                                                  input logic [1:0]      off);
    logic        [XLEN-1:0] aligned;
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [XLEN-1:0] ext;
    aligned = word >> {off, 3'b000};
    sb      = aligned[7:0];
    sh      = aligned[15:0];
    case (f3)
      3'd0:    ext = sb;
      3'd1:    ext = sh;
      3'd2:    ext = aligned;
      3'd4:    ext = {{(XLEN-8){1'b0}}, aligned[7:0]};
      3'd5:    ext = {{(XLEN-16){1'b0}}, aligned[15:0]};
      default: ext = '0;
    endcase
    return ext;
  endfunction

  // Request decode
  assign idx      = req_addr[AW-1:0];
  assign word_sel = idx[AW-1:2];
  assign size     = req_funct3[1:0];
  assign accept   = req_valid && (state == S_IDLE);

  always_comb begin
    f3_bad       = req_we ? (req_funct3 > 3'd2)
                          : (req_funct3 inside {3'd3, 3'd6, 3'd7});
    misaligned   = ((size == 2'd1) && req_addr[0]) ||
                   ((size == 2'd2) && (req_addr[1:0] != 2'd0));
    out_of_range = (req_addr >= DEPTH_L);
    acc_err      = f3_bad || misaligned || out_of_range;

    lanes       = 4'b0000;
    wdata_lanes = req_wdata;
    case (size)
      2'd0: begin
        lanes       = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lanes       = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        lanes       = 4'b1111;
        wdata_lanes = req_wdata;
      end
      default: begin
        lanes       = 4'b0000;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  // The whole aligned word is fetched; the load lanes are picked by shifting.
  assign rd_word = {mem[{word_sel, 2'd3}], mem[{word_sel, 2'd2}],
                    mem[{word_sel, 2'd1}], mem[{word_sel, 2'd0}]};

  assign ld_result = (req_we || acc_err) ? '0
                                         : load_extend(req_funct3, rd_word, req_addr[1:0]);

  // Memory array: written at the accepting edge, never reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (lanes[k]) begin
          mem[{word_sel, 2'(k)}] <= wdata_lanes[8*k +: 8];
        end
      end
    end
  end

  // Stage p0: load result captured at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_p0 <= ld_result;
      hold_err_p0  <= acc_err;
    end
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    load_resp  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (LATENCY == 1) begin
            state_n   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) begin
          state_n   = S_RESP;
          load_resp = 1'b1;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Stage p1: response registers, loaded on entry to RESP and held afterwards.
  // With LATENCY=1 the entry edge is the accept edge, so the result bypasses
  // the holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (load_resp) begin
      resp_rdata <= (state == S_IDLE) ? ld_result : hold_data_p0;
      resp_err   <= (state == S_IDLE) ? acc_err   : hold_err_p0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// ----------------------------------------------------------------------------
// tb_dmem_lsu
//   Directed bench for dmem_lsu. Two instances share the request inputs: one
//   built with LATENCY=1 (suffix a_) and one with LATENCY=3 (suffix b_).
//   Each request is issued when both are idle, and both responses are checked.
// ----------------------------------------------------------------------------
module tb_dmem_lsu;

  localparam int DEPTH = 1024;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        a_ready, a_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_ready, b_valid, b_err;
  logic [31:0] b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int          a_lat, b_lat, a_cnt, b_cnt, b_busy;
  logic [31:0] a_data, b_data;
  logic        a_e, b_e;

  always #5 clk = ~clk;

  dmem_lsu #(.XLEN(32), .DEPTH_BYTES(DEPTH), .LATENCY(LAT_A)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_valid), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  dmem_lsu #(.XLEN(32), .DEPTH_BYTES(DEPTH), .LATENCY(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_valid), .resp_rdata(b_rdata), .resp_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/a_ready"}, 32'(a_ready), 32'd1);
    check({tag, "/a_valid"}, 32'(a_valid), 32'd0);
    check({tag, "/a_rdata"}, a_rdata, 32'd0);
    check({tag, "/a_err"},   32'(a_err),   32'd0);
    check({tag, "/b_ready"}, 32'(b_ready), 32'd1);
    check({tag, "/b_valid"}, 32'(b_valid), 32'd0);
    check({tag, "/b_rdata"}, b_rdata, 32'd0);
    check({tag, "/b_err"},   32'(b_err),   32'd0);
  endtask

  // Issue one request and observe both responses for 8 cycles.
  // Sample k is taken 1 time unit after the k-th edge, counting the accept
  // edge as edge 1, so a response seen at sample k arrives k cycles later.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (!(a_ready && b_ready) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("both_ready_before_req", 32'({a_ready, b_ready}), 32'b11);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a_lat = 0; b_lat = 0; a_cnt = 0; b_cnt = 0; b_busy = 0;
    a_data = 32'hx; b_data = 32'hx; a_e = 1'bx; b_e = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (a_valid) begin
        a_cnt++;
        if (a_lat == 0) begin a_lat = k; a_data = a_rdata; a_e = a_err; end
      end
      if (b_valid) begin
        b_cnt++;
        if (b_lat == 0) begin b_lat = k; b_data = b_rdata; b_e = b_err; end
      end
      if (!b_ready) b_busy++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err);
    do_req(we, f3, addr, wdata);
    check({tag, "/a_data"},  a_data, exp_data);
    check({tag, "/a_err"},   32'(a_e), 32'(exp_err));
    check({tag, "/a_lat"},   32'(a_lat), 32'(LAT_A));
    check({tag, "/a_pulses"}, 32'(a_cnt), 32'd1);
    check({tag, "/b_data"},  b_data, exp_data);
    check({tag, "/b_err"},   32'(b_e), 32'(exp_err));
    check({tag, "/b_lat"},   32'(b_lat), 32'(LAT_B));
    check({tag, "/b_pulses"}, 32'(b_cnt), 32'd1);
    // Busy through WAIT and RESP, ready again the cycle after the response.
    check({tag, "/b_busy"},  32'(b_busy), 32'(LAT_B));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b_first, b_second, b_n, a_n;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #1;
    check_reset_outputs("reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store and load
    txn("sw_10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    txn("lw_10",  1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);

    // Byte store into an existing word, signed/unsigned byte loads
    txn("sw_20",  1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0,        1'b0);
    txn("sb_21",  1'b1, 3'd0, 32'h21, 32'h12345680, 32'h0,        1'b0);
    txn("lb_21",  1'b0, 3'd0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0);
    txn("lbu_21", 1'b0, 3'd4, 32'h21, 32'h0,        32'h00000080, 1'b0);
    txn("lw_20",  1'b0, 3'd2, 32'h20, 32'h0,        32'h11228044, 1'b0);
    txn("lb_23",  1'b0, 3'd0, 32'h23, 32'h0,        32'h00000011, 1'b0);

    // Halfword stores in both halves, signed/unsigned halfword loads
    txn("sh_32",  1'b1, 3'd1, 32'h32, 32'hABCD8001, 32'h0,        1'b0);
    txn("sh_30",  1'b1, 3'd1, 32'h30, 32'h55557FFE, 32'h0,        1'b0);
    txn("lh_32",  1'b0, 3'd1, 32'h32, 32'h0,        32'hFFFF8001, 1'b0);
    txn("lhu_32", 1'b0, 3'd5, 32'h32, 32'h0,        32'h00008001, 1'b0);
    txn("lh_30",  1'b0, 3'd1, 32'h30, 32'h0,        32'h00007FFE, 1'b0);
    txn("lw_30",  1'b0, 3'd2, 32'h30, 32'h0,        32'h80017FFE, 1'b0);
    txn("lb_33",  1'b0, 3'd0, 32'h33, 32'h0,        32'hFFFFFF80, 1'b0);

    // Rejected accesses leave memory untouched
    txn("sw_08",     1'b1, 3'd2, 32'h08,  32'h55667788, 32'h0, 1'b0);
    txn("lw_0a_mis", 1'b0, 3'd2, 32'h0A,  32'h0,        32'h0, 1'b1);
    txn("sh_0b_mis", 1'b1, 3'd1, 32'h0B,  32'hAAAAAAAA, 32'h0, 1'b1);
    txn("lw_oob",    1'b0, 3'd2, DEPTH,   32'h0,        32'h0, 1'b1);
    txn("ld_f3_3",   1'b0, 3'd3, 32'h08,  32'h0,        32'h0, 1'b1);
    txn("ld_f3_6",   1'b0, 3'd6, 32'h08,  32'h0,        32'h0, 1'b1);
    txn("sw_oob",    1'b1, 3'd2, DEPTH + 32'h08, 32'hBADBAD00, 32'h0, 1'b1);
    txn("st_f3_4",   1'b1, 3'd4, 32'h08,  32'hCCCCCCCC, 32'h0, 1'b1);
    txn("lw_08",     1'b0, 3'd2, 32'h08,  32'h0,        32'h55667788, 1'b0);

    // Back-to-back: request held high for 16 cycles
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    b_first = -1; b_second = -1; b_n = 0; a_n = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (a_valid) a_n++;
      if (b_valid) begin
        b_n++;
        if (b_first < 0) b_first = c;
        else if (b_second < 0) b_second = c;
      end
    end
    req_valid = 1'b0;
    check("b2b/a_responses", 32'(a_n), 32'd8);
    check("b2b/b_responses", 32'(b_n), 32'd4);
    check("b2b/b_spacing",   32'(b_second - b_first), 32'(LAT_B + 1));
    check("b2b/b_data",      b_rdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;

    // Reset while the LATENCY=3 instance waits on an accepted store
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFEF00D;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_reset/b_in_wait", 32'({b_ready, b_valid}), 32'b00);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("mid_reset/held_valid", 32'({a_valid, b_valid}), 32'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("post_reset/ready", 32'({a_ready, b_ready}), 32'b11);
      check("post_reset/valid", 32'({a_valid, b_valid}), 32'b00);
    end
    txn("lw_40_after_reset", 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
